// File: rtl/kvs_tx_arbiter_if.sv
// Stream bundle around the transmit arbiter: NUM_PORTS flattened input streams and one output stream.
// slave: the arbiter. master: the sources and the to_net sink.
interface kvs_tx_arbiter_if #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 64
);
  localparam int unsigned KEEP_W = DATA_WIDTH / 8;

  logic [NUM_PORTS*DATA_WIDTH-1:0] in_tdata;
  logic [NUM_PORTS*KEEP_W-1:0]     in_tkeep;
  logic [NUM_PORTS*USER_WIDTH-1:0] in_tuser;
  logic [NUM_PORTS-1:0]            in_tlast;
  logic [NUM_PORTS-1:0]            in_tvalid;
  logic [NUM_PORTS-1:0]            in_tready;

  logic [DATA_WIDTH-1:0]           out_tdata;
  logic [KEEP_W-1:0]               out_tkeep;
  logic [USER_WIDTH-1:0]           out_tuser;
  logic                            out_tlast;
  logic                            out_tvalid;
  logic                            out_tready;

  modport slave (
    input  in_tdata, in_tkeep, in_tuser, in_tlast, in_tvalid,
    output in_tready,
    output out_tdata, out_tkeep, out_tuser, out_tlast, out_tvalid,
    input  out_tready
  );

  modport master (
    output in_tdata, in_tkeep, in_tuser, in_tlast, in_tvalid,
    input  in_tready,
    input  out_tdata, out_tkeep, out_tuser, out_tlast, out_tvalid,
    output out_tready
  );
endinterface

// File: rtl/kvs_tx_arbiter.sv
// Packet-atomic round-robin merge of several AXI-Stream sources onto the to_net stream.
// A granted source owns the output until its tlast beat is accepted; one output register stage.
module kvs_tx_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 64,
  parameter int unsigned GRANT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                clk_390,
  input  logic                clk_390_rst,
  kvs_tx_arbiter_if.slave     bus,
  output logic [GRANT_W-1:0]  grant_id,
  output logic                busy,
  output logic [31:0]         pkt_count
);
  localparam int unsigned KEEP_W = DATA_WIDTH / 8;

  typedef enum logic {IDLE, XFER} state_e;

  state_e                 state_q;
  logic [GRANT_W-1:0]     grant_q;
  logic [GRANT_W-1:0]     last_grant_q;
  logic                   busy_q;
  logic [31:0]            pkt_count_q;
  logic [DATA_WIDTH-1:0]  out_tdata_q;
  logic [KEEP_W-1:0]      out_tkeep_q;
  logic [USER_WIDTH-1:0]  out_tuser_q;
  logic                   out_tlast_q;
  logic                   out_tvalid_q;

  logic [GRANT_W-1:0]     pick_c;
  logic                   any_valid_c;
  logic [DATA_WIDTH-1:0]  sel_tdata_c;
  logic [KEEP_W-1:0]      sel_tkeep_c;
  logic [USER_WIDTH-1:0]  sel_tuser_c;
  logic                   sel_tlast_c;
  logic                   sel_tvalid_c;
  logic                   take_c;
  logic                   in_fire_c;
  logic                   out_fire_c;
  logic [NUM_PORTS-1:0]   in_tready_c;

  // Round-robin scan starting just after the last granted port
  always_comb begin : pick_next
    int unsigned idx;
    pick_c      = '0;
    any_valid_c = 1'b0;
    idx         = 0;
    for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
      idx = (32'(last_grant_q) + off) % NUM_PORTS;
      if (!any_valid_c && bus.in_tvalid[idx]) begin
        any_valid_c = 1'b1;
        pick_c      = GRANT_W'(idx);
      end
    end
  end

  always_comb begin : sel_mux
    sel_tdata_c  = '0;
    sel_tkeep_c  = '0;
    sel_tuser_c  = '0;
    sel_tlast_c  = 1'b0;
    sel_tvalid_c = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == GRANT_W'(i)) begin
        sel_tdata_c  = bus.in_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_tkeep_c  = bus.in_tkeep[i*KEEP_W +: KEEP_W];
        sel_tuser_c  = bus.in_tuser[i*USER_WIDTH +: USER_WIDTH];
        sel_tlast_c  = bus.in_tlast[i];
        sel_tvalid_c = bus.in_tvalid[i];
      end
    end
  end

  // Only the granted port may move a beat, and only when the output register can take it
  assign take_c     = (state_q == XFER) && (!out_tvalid_q || bus.out_tready);
  assign in_fire_c  = take_c && sel_tvalid_c;
  assign out_fire_c = out_tvalid_q && bus.out_tready;

  always_comb begin : ready_dec
    in_tready_c = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (take_c && (grant_q == GRANT_W'(i))) in_tready_c[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_390 or posedge clk_390_rst) begin
    if (clk_390_rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GRANT_W'(NUM_PORTS - 1);
      busy_q       <= 1'b0;
      pkt_count_q  <= '0;
      out_tdata_q  <= '0;
      out_tkeep_q  <= '0;
      out_tuser_q  <= '0;
      out_tlast_q  <= 1'b0;
      out_tvalid_q <= 1'b0;
    end else begin
      if (in_fire_c) begin
        out_tdata_q  <= sel_tdata_c;
        out_tkeep_q  <= sel_tkeep_c;
        out_tuser_q  <= sel_tuser_c;
        out_tlast_q  <= sel_tlast_c;
        out_tvalid_q <= 1'b1;
      end else if (out_fire_c) begin
        out_tvalid_q <= 1'b0;
      end

      if (out_fire_c && out_tlast_q) pkt_count_q <= pkt_count_q + 32'd1;

      unique case (state_q)
        IDLE: begin
          if (any_valid_c) begin
            grant_q <= pick_c;
            busy_q  <= 1'b1;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (in_fire_c && sel_tlast_c) begin
            last_grant_q <= grant_q;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_tready  = in_tready_c;
  assign bus.out_tdata  = out_tdata_q;
  assign bus.out_tkeep  = out_tkeep_q;
  assign bus.out_tuser  = out_tuser_q;
  assign bus.out_tlast  = out_tlast_q;
  assign bus.out_tvalid = out_tvalid_q;
  assign grant_id       = grant_q;
  assign busy           = busy_q;
  assign pkt_count      = pkt_count_q;
endmodule

// File: tb/tb_kvs_tx_arbiter.sv
// Directed bench for kvs_tx_arbiter: cycle-exact vector tables plus hand-written multi-cycle sequences.
module tb_kvs_tx_arbiter;
  localparam int unsigned NP = 4;

  logic        clk = 1'b0;
  logic        clk_390_rst;
  logic [1:0]  grant_id;
  logic        busy;
  logic [31:0] pkt_count;

  kvs_tx_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(64), .USER_WIDTH(64)) bus ();

  kvs_tx_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(64), .USER_WIDTH(64), .GRANT_W(2)) dut (
    .clk_390     (clk),
    .clk_390_rst (clk_390_rst),
    .bus         (bus),
    .grant_id    (grant_id),
    .busy        (busy),
    .pkt_count   (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [63:0] user;
  } beat_t;

  typedef struct {
    logic       rst_before;
    logic [3:0] vld;
    logic [3:0] lst;
    logic [7:0] d;
    logic [7:0] kp;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_vld;
    logic [7:0] e_d;
    logic [7:0] e_kp;
    logic       e_lst;
    logic [2:0] e_usr;
    logic       e_busy;
    logic [1:0] e_gnt;
    logic [7:0] e_pkt;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc_n  = 0;
  logic  onehot_err = 1'b0;
  logic [3:0] hold = 4'h0;
  beat_t srcq [NP][$];
  beat_t obs_q[$];
  int    obs_cyc[$];
  beat_t expq[$];
  vec_t  vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic r, logic [3:0] vld, logic [3:0] lst, logic [7:0] d, logic [7:0] kp,
                              logic ordy, logic [3:0] erdy, logic evld, logic [7:0] ed, logic [7:0] ekp,
                              logic elst, logic [2:0] eusr, logic ebusy, logic [1:0] egnt, logic [7:0] epkt);
    vec_t v;
    v.rst_before = r;  v.vld = vld;    v.lst = lst;   v.d = d;       v.kp = kp;
    v.ordy = ordy;     v.e_rdy = erdy; v.e_vld = evld; v.e_d = ed;   v.e_kp = ekp;
    v.e_lst = elst;    v.e_usr = eusr; v.e_busy = ebusy; v.e_gnt = egnt; v.e_pkt = epkt;
    return v;
  endfunction

  function automatic beat_t mkb(logic [63:0] data, logic last, logic [63:0] user);
    beat_t b;
    b.data = data; b.keep = 8'hFF; b.last = last; b.user = user;
    return b;
  endfunction

  task automatic do_reset();
    clk_390_rst    = 1'b1;
    bus.in_tvalid  = '0;
    bus.in_tlast   = '0;
    bus.in_tdata   = '0;
    bus.in_tkeep   = '0;
    bus.in_tuser   = '0;
    bus.out_tready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clk_390_rst = 1'b0;
    for (int p = 0; p < NP; p++) srcq[p].delete();
    obs_q.delete();
    obs_cyc.delete();
    hold       = 4'h0;
    onehot_err = 1'b0;
    cyc_n      = 0;
  endtask

  task automatic apply_vec(input vec_t v);
    for (int p = 0; p < NP; p++) begin
      bus.in_tdata[p*64 +: 64] = 64'(v.d);
      bus.in_tkeep[p*8 +: 8]   = v.kp;
      bus.in_tuser[p*64 +: 64] = 64'(p);
    end
    bus.in_tlast   = v.lst;
    bus.in_tvalid  = v.vld;
    bus.out_tready = v.ordy;
  endtask

  // Source model: each port presents the head of its queue unless held
  task automatic begin_cycle();
    for (int p = 0; p < NP; p++) begin
      if (srcq[p].size() > 0 && !hold[p]) begin
        bus.in_tdata[p*64 +: 64] = srcq[p][0].data;
        bus.in_tkeep[p*8 +: 8]   = srcq[p][0].keep;
        bus.in_tuser[p*64 +: 64] = srcq[p][0].user;
        bus.in_tlast[p]          = srcq[p][0].last;
        bus.in_tvalid[p]         = 1'b1;
      end else begin
        bus.in_tdata[p*64 +: 64] = '0;
        bus.in_tkeep[p*8 +: 8]   = '0;
        bus.in_tuser[p*64 +: 64] = '0;
        bus.in_tlast[p]          = 1'b0;
        bus.in_tvalid[p]         = 1'b0;
      end
    end
    #1;
  endtask

  task automatic end_cycle();
    logic [3:0] f;
    logic       of;
    beat_t      ob;
    f  = bus.in_tvalid & bus.in_tready;
    of = bus.out_tvalid && bus.out_tready;
    ob.data = bus.out_tdata; ob.keep = bus.out_tkeep; ob.last = bus.out_tlast; ob.user = bus.out_tuser;
    if ($countones(bus.in_tready) > 1) onehot_err = 1'b1;
    @(posedge clk);
    for (int p = 0; p < NP; p++) if (f[p]) void'(srcq[p].pop_front());
    if (of) begin
      obs_q.push_back(ob);
      obs_cyc.push_back(cyc_n);
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      begin_cycle();
      end_cycle();
    end
  endtask

  task automatic chk_obs(input string name);
    chk({name, "_count"}, 64'(obs_q.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < obs_q.size(); i++) begin
      chk($sformatf("%s_data%0d", name, i), obs_q[i].data, expq[i].data);
      chk($sformatf("%s_user%0d", name, i), obs_q[i].user, expq[i].user);
      chk($sformatf("%s_last%0d", name, i), 64'(obs_q[i].last), 64'(expq[i].last));
    end
  endtask

  initial begin
    // Port 1 three-beat packet, then all four ports offering single-beat packets
    vecs.push_back(mk(1'b1, 4'h2, 4'h0, 8'h11, 8'hFF, 1'b1, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 2'd0, 8'd0));
    vecs.push_back(mk(1'b0, 4'h2, 4'h0, 8'h11, 8'hFF, 1'b1, 4'h2, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 2'd1, 8'd0));
    vecs.push_back(mk(1'b0, 4'h2, 4'h0, 8'h12, 8'hFF, 1'b1, 4'h2, 1'b1, 8'h11, 8'hFF, 1'b0, 3'd1, 1'b1, 2'd1, 8'd0));
    vecs.push_back(mk(1'b0, 4'h2, 4'h2, 8'h13, 8'h0F, 1'b1, 4'h2, 1'b1, 8'h12, 8'hFF, 1'b0, 3'd1, 1'b1, 2'd1, 8'd0));
    vecs.push_back(mk(1'b0, 4'h0, 4'h0, 8'h00, 8'hFF, 1'b1, 4'h0, 1'b1, 8'h13, 8'h0F, 1'b1, 3'd1, 1'b0, 2'd1, 8'd0));
    vecs.push_back(mk(1'b0, 4'h0, 4'h0, 8'h00, 8'hFF, 1'b1, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 2'd1, 8'd1));
    vecs.push_back(mk(1'b1, 4'hF, 4'hF, 8'h20, 8'hFF, 1'b1, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 2'd0, 8'd0));
    vecs.push_back(mk(1'b0, 4'hF, 4'hF, 8'h21, 8'hFF, 1'b1, 4'h1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 2'd0, 8'd0));
    vecs.push_back(mk(1'b0, 4'hF, 4'hF, 8'h22, 8'hFF, 1'b1, 4'h0, 1'b1, 8'h21, 8'hFF, 1'b1, 3'd0, 1'b0, 2'd0, 8'd0));
    vecs.push_back(mk(1'b0, 4'hF, 4'hF, 8'h23, 8'hFF, 1'b1, 4'h2, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 2'd1, 8'd1));
    vecs.push_back(mk(1'b0, 4'hF, 4'hF, 8'h24, 8'hFF, 1'b1, 4'h0, 1'b1, 8'h23, 8'hFF, 1'b1, 3'd1, 1'b0, 2'd1, 8'd1));
    vecs.push_back(mk(1'b0, 4'hF, 4'hF, 8'h25, 8'hFF, 1'b1, 4'h4, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 2'd2, 8'd2));
    vecs.push_back(mk(1'b0, 4'hF, 4'hF, 8'h26, 8'hFF, 1'b1, 4'h0, 1'b1, 8'h25, 8'hFF, 1'b1, 3'd2, 1'b0, 2'd2, 8'd2));
    vecs.push_back(mk(1'b0, 4'hF, 4'hF, 8'h27, 8'hFF, 1'b1, 4'h8, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 2'd3, 8'd3));
    vecs.push_back(mk(1'b0, 4'hF, 4'hF, 8'h28, 8'hFF, 1'b1, 4'h0, 1'b1, 8'h27, 8'hFF, 1'b1, 3'd3, 1'b0, 2'd3, 8'd3));
    vecs.push_back(mk(1'b0, 4'hF, 4'hF, 8'h29, 8'hFF, 1'b1, 4'h1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 2'd0, 8'd4));
    vecs.push_back(mk(1'b0, 4'hF, 4'hF, 8'h2A, 8'hFF, 1'b1, 4'h0, 1'b1, 8'h29, 8'hFF, 1'b1, 3'd0, 1'b0, 2'd0, 8'd4));

    @(negedge clk);
    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].rst_before) do_reset();
      apply_vec(vecs[k]);
      #1;
      chk($sformatf("v%0d_in_tready", k), 64'(bus.in_tready), 64'(vecs[k].e_rdy));
      chk($sformatf("v%0d_out_tvalid", k), 64'(bus.out_tvalid), 64'(vecs[k].e_vld));
      chk($sformatf("v%0d_busy", k), 64'(busy), 64'(vecs[k].e_busy));
      chk($sformatf("v%0d_grant_id", k), 64'(grant_id), 64'(vecs[k].e_gnt));
      chk($sformatf("v%0d_pkt_count", k), 64'(pkt_count), 64'(vecs[k].e_pkt));
      if (vecs[k].e_vld) begin
        chk($sformatf("v%0d_out_tdata", k), bus.out_tdata, 64'(vecs[k].e_d));
        chk($sformatf("v%0d_out_tkeep", k), 64'(bus.out_tkeep), 64'(vecs[k].e_kp));
        chk($sformatf("v%0d_out_tlast", k), 64'(bus.out_tlast), 64'(vecs[k].e_lst));
        chk($sformatf("v%0d_out_tuser", k), bus.out_tuser, 64'(vecs[k].e_usr));
      end
      @(posedge clk);
      @(negedge clk);
    end

    // Ports 0 and 2 valid together after reset: port 0 first, one bubble, then port 2
    do_reset();
    bus.out_tready = 1'b1;
    srcq[0].push_back(mkb(64'hA0, 1'b0, 64'd0));
    srcq[0].push_back(mkb(64'hA1, 1'b1, 64'd0));
    srcq[2].push_back(mkb(64'hC0, 1'b1, 64'd2));
    run(8);
    expq.delete();
    expq.push_back(mkb(64'hA0, 1'b0, 64'd0));
    expq.push_back(mkb(64'hA1, 1'b1, 64'd0));
    expq.push_back(mkb(64'hC0, 1'b1, 64'd2));
    chk_obs("two_src");
    if (obs_cyc.size() == 3) begin
      chk("two_src_cyc0", 64'(obs_cyc[0]), 64'd2);
      chk("two_src_cyc1", 64'(obs_cyc[1]), 64'd3);
      chk("two_src_cyc2", 64'(obs_cyc[2]), 64'd5);
    end
    chk("two_src_pkt_count", 64'(pkt_count), 64'd2);
    chk("two_src_onehot", 64'(onehot_err), 64'd0);

    // Output stall of 5 cycles with beat B1 in the output register
    do_reset();
    bus.out_tready = 1'b1;
    for (int i = 0; i < 4; i++) srcq[1].push_back(mkb(64'hB0 + 64'(i), (i == 3), 64'd1));
    run(3);
    bus.out_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      begin_cycle();
      chk($sformatf("stall%0d_tvalid", i), 64'(bus.out_tvalid), 64'd1);
      chk($sformatf("stall%0d_tdata", i), bus.out_tdata, 64'hB1);
      chk($sformatf("stall%0d_tlast", i), 64'(bus.out_tlast), 64'd0);
      chk($sformatf("stall%0d_in_tready", i), 64'(bus.in_tready), 64'd0);
      end_cycle();
    end
    bus.out_tready = 1'b1;
    run(10);
    expq.delete();
    for (int i = 0; i < 4; i++) expq.push_back(mkb(64'hB0 + 64'(i), (i == 3), 64'd1));
    chk_obs("stall");
    chk("stall_pkt_count", 64'(pkt_count), 64'd1);

    // Granted port 0 goes quiet mid-packet while port 3 waits
    do_reset();
    bus.out_tready = 1'b1;
    for (int i = 0; i < 3; i++) srcq[0].push_back(mkb(64'hD0 + 64'(i), (i == 2), 64'd0));
    srcq[3].push_back(mkb(64'hE3, 1'b1, 64'd3));
    run(2);
    hold = 4'h1;
    for (int i = 0; i < 4; i++) begin
      begin_cycle();
      chk($sformatf("gap%0d_in_tready", i), 64'(bus.in_tready), 64'h1);
      chk($sformatf("gap%0d_grant", i), 64'(grant_id), 64'd0);
      chk($sformatf("gap%0d_busy", i), 64'(busy), 64'd1);
      end_cycle();
    end
    hold = 4'h0;
    run(12);
    expq.delete();
    for (int i = 0; i < 3; i++) expq.push_back(mkb(64'hD0 + 64'(i), (i == 2), 64'd0));
    expq.push_back(mkb(64'hE3, 1'b1, 64'd3));
    chk_obs("gap");
    chk("gap_pkt_count", 64'(pkt_count), 64'd2);
    chk("gap_onehot", 64'(onehot_err), 64'd0);

    // Reset during beat 2 of a 4-beat packet on port 2
    do_reset();
    bus.out_tready = 1'b1;
    srcq[2].push_back(mkb(64'hF0, 1'b1, 64'd2));
    for (int i = 0; i < 4; i++) srcq[2].push_back(mkb(64'hF8 + 64'(i), (i == 3), 64'd2));
    run(4);
    begin_cycle();
    chk("prerst_pkt_count", 64'(pkt_count), 64'd1);
    chk("prerst_tdata", bus.out_tdata, 64'hF8);
    clk_390_rst = 1'b1;
    #1;
    chk("rst_out_tvalid", 64'(bus.out_tvalid), 64'd0);
    chk("rst_in_tready", 64'(bus.in_tready), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    for (int p = 0; p < NP; p++) srcq[p].delete();
    obs_q.delete();
    obs_cyc.delete();
    clk_390_rst = 1'b0;
    srcq[2].push_back(mkb(64'h62, 1'b1, 64'd2));
    srcq[0].push_back(mkb(64'h60, 1'b1, 64'd0));
    run(8);
    expq.delete();
    expq.push_back(mkb(64'h60, 1'b1, 64'd0));
    expq.push_back(mkb(64'h62, 1'b1, 64'd2));
    chk_obs("after_rst");
    chk("after_rst_pkt_count", 64'(pkt_count), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
